// File: rtl/mpu_access_ctrl.sv
// Request sequencer that checks each CPU access against the combinational MPU,
// forwards allowed requests to memory and records syndrome/lockout state for blocked ones.
module mpu_access_ctrl #(
  parameter int LOCK_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             req_write,
  input  logic             req_exec,
  input  logic             req_priv,
  output logic [31:0]      mpu_addr,
  output logic             mpu_is_write,
  output logic             mpu_is_exec,
  output logic             mpu_priv,
  input  logic             mpu_violation,
  input  logic             mpu_allowed,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             resp_valid,
  output logic             resp_fault,
  output logic [31:0]      fault_addr,
  output logic [1:0]       fault_type,
  output logic [CNT_W-1:0] fault_count,
  output logic             trap,
  output logic             locked,
  input  logic             fault_clear
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FWD   = 3'd2,
    RESP  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_LVL = CNT_W'(LOCK_THRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [1:0] type_code(input logic is_write, input logic is_exec);
    if (is_exec) begin
      return 2'b10;
    end else if (is_write) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             lock_reject_s;
  logic             counted_r;
  logic [CNT_W-1:0] inc_s;

  assign lock_reject_s = locked & ~priv_r_view();
  function automatic logic priv_r_view();
    return mpu_priv;
  endfunction

  // A colliding clear restarts the count from zero before the new violation is added.
  assign inc_s = sat_inc(fault_clear ? {CNT_W{1'b0}} : fault_count);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; anything but a clean allowed verdict is treated as a violation
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_nxt_s = CHECK;
        else           state_nxt_s = IDLE;
      end
      CHECK: begin
        if (lock_reject_s)                       state_nxt_s = FAULT;
        else if (mpu_allowed && !mpu_violation)  state_nxt_s = FWD;
        else                                     state_nxt_s = FAULT;
      end
      FWD: begin
        if (mem_ready) state_nxt_s = RESP;
        else           state_nxt_s = FWD;
      end
      RESP:    state_nxt_s = IDLE;
      FAULT:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    case (state_r)
      IDLE:    req_ready = 1'b1;
      CHECK:   req_ready = 1'b0;
      FWD:     mem_valid = 1'b1;
      RESP:    resp_valid = 1'b1;
      FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Request holding registers (drive the MPU) and counted-violation flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mpu_addr     <= 32'h0000_0000;
      mpu_is_write <= 1'b0;
      mpu_is_exec  <= 1'b0;
      mpu_priv     <= 1'b0;
      counted_r    <= 1'b0;
    end else begin
      if (state_r == IDLE && req_valid) begin
        mpu_addr     <= req_addr;
        mpu_is_write <= req_write;
        mpu_is_exec  <= req_exec;
        mpu_priv     <= req_priv;
      end else begin
        mpu_addr     <= mpu_addr;
        mpu_is_write <= mpu_is_write;
        mpu_is_exec  <= mpu_is_exec;
        mpu_priv     <= mpu_priv;
      end
      counted_r <= (state_r == CHECK) && (state_nxt_s == FAULT) && !lock_reject_s;
    end
  end

  // Fault status: a counted violation in FAULT takes priority over fault_clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap        <= 1'b0;
      locked      <= 1'b0;
      fault_count <= {CNT_W{1'b0}};
      fault_addr  <= 32'h0000_0000;
      fault_type  <= 2'b00;
    end else if (state_r == FAULT && counted_r) begin
      trap        <= 1'b1;
      fault_count <= inc_s;
      locked      <= (locked && !fault_clear) || (inc_s >= LOCK_LVL);
      if (!trap || fault_clear) begin
        fault_addr <= mpu_addr;
        fault_type <= type_code(mpu_is_write, mpu_is_exec);
      end else begin
        fault_addr <= fault_addr;
        fault_type <= fault_type;
      end
    end else if (fault_clear) begin
      trap        <= 1'b0;
      locked      <= 1'b0;
      fault_count <= {CNT_W{1'b0}};
      fault_addr  <= 32'h0000_0000;
      fault_type  <= 2'b00;
    end else begin
      trap        <= trap;
      locked      <= locked;
      fault_count <= fault_count;
      fault_addr  <= fault_addr;
      fault_type  <= fault_type;
    end
  end

endmodule
